// File: rtl/wbfifo_endpoint.sv
// Pipelined wishbone slave with a stream-filled RX FIFO popped by bus reads
// and a bus-filled TX FIFO drained to a stream sink. Level interrupts follow
// FIFO occupancy against programmable thresholds.
module wbfifo_endpoint #(
    parameter int unsigned DW     = 32,
    parameter int unsigned LGFLEN = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [1:0]    i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_wb_ack,
    output logic          o_wb_stall,
    output logic [DW-1:0] o_wb_data,
    output logic          o_wb_err,
    input  logic          i_rx_stb,
    input  logic [DW-1:0] i_rx_data,
    output logic          o_rx_busy,
    output logic          o_tx_stb,
    output logic [DW-1:0] o_tx_data,
    input  logic          i_tx_busy,
    output logic          o_rx_int,
    output logic          o_tx_int
);

    localparam int unsigned DEPTH = 1 << LGFLEN;
    localparam int unsigned FW    = LGFLEN + 1;

    localparam logic [LGFLEN-1:0] PTR_ONE  = 1;
    localparam logic [FW-1:0]     FILL_ONE = 1;
    localparam logic [FW-1:0]     FILL_MAX = FW'(DEPTH);

    logic [DW-1:0] rx_mem [DEPTH];
    logic [DW-1:0] tx_mem [DEPTH];

    logic [LGFLEN-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [LGFLEN-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [FW-1:0]     rx_fill_q, rx_fill_d, tx_fill_q, tx_fill_d;
    logic [FW-1:0]     rx_thresh_q, rx_thresh_d, tx_thresh_q, tx_thresh_d;
    logic              rx_ovfl_q, rx_ovfl_d, bus_err_q, bus_err_d;
    logic              rx_busy_q, rx_busy_d;
    logic              rx_int_q, rx_int_d, tx_int_q, tx_int_d;
    logic              ack_q, ack_d, err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic accept, rd_data, wr_data, wr_ctrl, wr_thr;
    logic rx_flush, tx_flush, rx_push, rx_pop, rx_drop, tx_push, tx_pop;
    logic resp_err;
    logic [DW-1:0] status;
    logic [FW-1:0] tx_free;
    logic unused_wdata;

    assign unused_wdata = ^i_wb_data;

    // Decode the bus request and the per-FIFO push/pop/flush events.
    always_comb begin
        accept   = i_wb_cyc && i_wb_stb;
        rd_data  = accept && !i_wb_we && (i_wb_addr == 2'd0);
        wr_data  = accept && i_wb_we && (i_wb_addr == 2'd0);
        wr_ctrl  = accept && i_wb_we && (i_wb_addr == 2'd1);
        wr_thr   = accept && i_wb_we && (i_wb_addr == 2'd2);
        rx_flush = wr_ctrl && i_wb_data[1];
        tx_flush = wr_ctrl && i_wb_data[0];
        rx_pop   = rd_data && (rx_fill_q != '0);
        // Flush beats an incoming stream word, so it neither lands nor overflows.
        rx_push  = i_rx_stb && !rx_busy_q && !rx_flush;
        rx_drop  = i_rx_stb && rx_busy_q && !rx_flush;
        tx_push  = wr_data && (tx_fill_q != FILL_MAX);
        tx_pop   = (tx_fill_q != '0) && !i_tx_busy && !tx_flush;
        resp_err = (rd_data && (rx_fill_q == '0)) || (wr_data && (tx_fill_q == FILL_MAX));
    end

    // Next-state for pointers and fill counters of both FIFOs.
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_fill_d = rx_fill_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_fill_d = tx_fill_q;
        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_fill_d = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
            if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
            if (rx_push && !rx_pop)      rx_fill_d = rx_fill_q + FILL_ONE;
            else if (!rx_push && rx_pop) rx_fill_d = rx_fill_q - FILL_ONE;
        end
        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_fill_d = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
            if (tx_push && !tx_pop)      tx_fill_d = tx_fill_q + FILL_ONE;
            else if (!tx_push && tx_pop) tx_fill_d = tx_fill_q - FILL_ONE;
        end
    end

    // Next-state for sticky flags, thresholds, interrupts and the bus response.
    always_comb begin
        rx_ovfl_d   = rx_ovfl_q;
        bus_err_d   = bus_err_q;
        rx_thresh_d = rx_thresh_q;
        tx_thresh_d = tx_thresh_q;
        if (wr_ctrl && i_wb_data[31]) rx_ovfl_d = 1'b0;
        if (wr_ctrl && i_wb_data[30]) bus_err_d = 1'b0;
        // A new overflow outranks a clear landing in the same cycle.
        if (rx_drop)  rx_ovfl_d = 1'b1;
        if (resp_err) bus_err_d = 1'b1;
        if (wr_thr) begin
            rx_thresh_d = i_wb_data[16 +: FW];
            tx_thresh_d = i_wb_data[0 +: FW];
        end

        rx_busy_d = (rx_fill_d == FILL_MAX);
        tx_free   = FILL_MAX - tx_fill_q;
        rx_int_d  = (rx_thresh_q != '0) && (rx_fill_q >= rx_thresh_q);
        tx_int_d  = (tx_thresh_q != '0) && (tx_free >= tx_thresh_q);

        status             = '0;
        status[31]         = rx_ovfl_q;
        status[30]         = bus_err_q;
        status[16 +: FW]   = rx_fill_q;
        status[0 +: FW]    = tx_fill_q;

        ack_d   = accept && !resp_err;
        err_d   = accept && resp_err;
        rdata_d = '0;
        if (accept && !i_wb_we) begin
            case (i_wb_addr)
                2'd0: rdata_d = rx_pop ? rx_mem[rx_rptr_q] : '0;
                2'd1: rdata_d = status;
                2'd2: begin
                    rdata_d[16 +: FW] = rx_thresh_q;
                    rdata_d[0 +: FW]  = tx_thresh_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

    // Control and status state with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_fill_q   <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_fill_q   <= '0;
            rx_thresh_q <= FILL_ONE;
            tx_thresh_q <= FILL_ONE;
            rx_ovfl_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            rx_int_q    <= 1'b0;
            tx_int_q    <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_fill_q   <= rx_fill_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_fill_q   <= tx_fill_d;
            rx_thresh_q <= rx_thresh_d;
            tx_thresh_q <= tx_thresh_d;
            rx_ovfl_q   <= rx_ovfl_d;
            bus_err_q   <= bus_err_d;
            rx_busy_q   <= rx_busy_d;
            rx_int_q    <= rx_int_d;
            tx_int_q    <= tx_int_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the fill counters.
    always_ff @(posedge i_clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= i_rx_data;
        if (tx_push) tx_mem[tx_wptr_q] <= i_wb_data;
    end

    // Outputs: TX head is masked while empty so idle/reset data reads as zero.
    always_comb begin
        o_wb_ack   = ack_q;
        o_wb_err   = err_q;
        o_wb_data  = rdata_q;
        o_wb_stall = 1'b0;
        o_rx_busy  = rx_busy_q;
        o_tx_stb   = (tx_fill_q != '0);
        o_tx_data  = o_tx_stb ? tx_mem[tx_rptr_q] : '0;
        o_rx_int   = rx_int_q;
        o_tx_int   = tx_int_q;
    end

endmodule

// File: tb/tb_wbfifo_endpoint.sv
// Scoreboard bench for wbfifo_endpoint: bus requests push expected responses,
// a negedge monitor pops and compares bus responses and TX stream words.
module tb_wbfifo_endpoint;

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic        i_clk, i_rst;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack, o_wb_stall, o_wb_err;
    logic [31:0] o_wb_data;
    logic        i_rx_stb;
    logic [31:0] i_rx_data;
    logic        o_rx_busy, o_tx_stb;
    logic [31:0] o_tx_data;
    logic        i_tx_busy, o_rx_int, o_tx_int;

    exp_t        exp_q[$];
    logic [31:0] tx_exp[$];
    int          vectors = 0;
    int          miscompares = 0;

    wbfifo_endpoint #(.DW(32), .LGFLEN(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
        .o_wb_err(o_wb_err),
        .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data), .o_rx_busy(o_rx_busy),
        .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
        .o_rx_int(o_rx_int), .o_tx_int(o_tx_int)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every bus response and every TX word transfer.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wb_ack || o_wb_err) begin
                exp_t e;
                check("wb_ack_err_exclusive", 32'(o_wb_ack && o_wb_err), 32'd0);
                if (exp_q.size() == 0) begin
                    check("wb_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_err", 32'(o_wb_err), 32'(e.err));
                    if (e.chk) check("wb_rdata", o_wb_data, e.data);
                end
            end
            if (o_tx_stb && !i_tx_busy) begin
                if (tx_exp.size() == 0) check("tx_unexpected_word", 32'd1, 32'd0);
                else check("tx_data", o_tx_data, tx_exp.pop_front());
            end
        end
    end

    // Drive one request for one clock; caller sets up any same-cycle stream input.
    task automatic bus_issue(input logic we, input logic [1:0] addr, input logic [31:0] data,
                             input logic exp_err, input logic [31:0] exp_data);
        exp_t e;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        e.err  = exp_err;
        e.chk  = !we;
        e.data = exp_data;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_idle();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic rx_push(input logic [31:0] data);
        i_rx_stb  = 1'b1;
        i_rx_data = data;
        @(posedge i_clk);
        #1;
        i_rx_stb = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;
        i_rx_stb = 0; i_rx_data = 0; i_tx_busy = 1'b1;
        tick(); tick();
        i_rst = 1'b0;
        tick();

        // 1: activity, then async reset while a response is pending.
        bus_issue(1'b1, 2'd0, 32'h55, 1'b0, 32'h0);
        bus_idle();
        rx_push(32'h11);
        tick();
        check("pre_reset_rx_int", 32'(o_rx_int), 32'd1);
        check("pre_reset_tx_stb", 32'(o_tx_stb), 32'd1);
        bus_issue(1'b1, 2'd0, 32'h66, 1'b0, 32'h0);
        #2 i_rst = 1'b1;
        #1;
        check("reset_ack_err", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
        check("reset_wb_data", o_wb_data, 32'd0);
        check("reset_flags", {26'd0, o_wb_stall, o_rx_busy, o_tx_stb, o_rx_int, o_tx_int, 1'b0},
              32'd0);
        check("reset_tx_data", o_tx_data, 32'd0);
        bus_idle();
        exp_q.delete();
        tick();
        i_rst = 1'b0;
        check("tx_int_at_release", 32'(o_tx_int), 32'd0);
        tick();
        check("tx_int_after_release", 32'(o_tx_int), 32'd1);
        bus_issue(1'b0, 2'd1, 32'h0, 1'b0, 32'h0000_0000);
        bus_idle();

        // 2: three stream words read back-to-back, fourth read underflows.
        rx_push(32'hA1);
        rx_push(32'hA2);
        rx_push(32'hA3);
        bus_issue(1'b0, 2'd0, 32'h0, 1'b0, 32'hA1);
        bus_issue(1'b0, 2'd0, 32'h0, 1'b0, 32'hA2);
        bus_issue(1'b0, 2'd0, 32'h0, 1'b0, 32'hA3);
        bus_issue(1'b0, 2'd0, 32'h0, 1'b1, 32'h0);
        bus_issue(1'b0, 2'd1, 32'h0, 1'b0, 32'h4000_0000);
        bus_issue(1'b1, 2'd1, 32'h4000_0000, 1'b0, 32'h0);
        bus_idle();

        // 3: fill TX while the sink is busy, overflow once, then drain.
        for (int i = 0; i < 16; i++) begin
            bus_issue(1'b1, 2'd0, 32'(i), 1'b0, 32'h0);
            tx_exp.push_back(32'(i));
        end
        bus_issue(1'b1, 2'd0, 32'hBAD, 1'b1, 32'h0);
        bus_issue(1'b0, 2'd1, 32'h0, 1'b0, 32'h4000_0010);
        bus_issue(1'b1, 2'd1, 32'h4000_0000, 1'b0, 32'h0);
        bus_idle();
        check("tx_full_stb", 32'(o_tx_stb), 32'd1);
        check("tx_full_int", 32'(o_tx_int), 32'd0);
        i_tx_busy = 1'b0;
        for (int i = 0; i < 40 && tx_exp.size() != 0; i++) @(posedge i_clk);
        #1;
        check("tx_drained", 32'(tx_exp.size()), 32'd0);
        check("tx_stb_after_drain", 32'(o_tx_stb), 32'd0);

        // 4: RX full, stream push collides with a bus pop.
        for (int i = 0; i < 16; i++) rx_push(32'h100 + 32'(i));
        check("rx_busy_full", 32'(o_rx_busy), 32'd1);
        i_rx_stb  = 1'b1;
        i_rx_data = 32'hDEAD;
        bus_issue(1'b0, 2'd0, 32'h0, 1'b0, 32'h100);
        i_rx_stb = 1'b0;
        check("rx_busy_after_pop", 32'(o_rx_busy), 32'd0);
        bus_issue(1'b0, 2'd1, 32'h0, 1'b0, 32'h800F_0000);
        bus_issue(1'b1, 2'd1, 32'h8000_0000, 1'b0, 32'h0);
        bus_issue(1'b0, 2'd1, 32'h0, 1'b0, 32'h000F_0000);
        bus_issue(1'b1, 2'd1, 32'h0000_0002, 1'b0, 32'h0);
        bus_idle();

        // 5: RX threshold of 4.
        bus_issue(1'b1, 2'd2, 32'h0004_0001, 1'b0, 32'h0);
        bus_issue(1'b0, 2'd2, 32'h0, 1'b0, 32'h0004_0001);
        bus_idle();
        rx_push(32'h1);
        rx_push(32'h2);
        rx_push(32'h3);
        tick();
        check("rx_int_below_thresh", 32'(o_rx_int), 32'd0);
        rx_push(32'h4);
        tick();
        check("rx_int_at_thresh", 32'(o_rx_int), 32'd1);
        bus_issue(1'b0, 2'd0, 32'h0, 1'b0, 32'h1);
        bus_idle();
        tick();
        check("rx_int_after_pop", 32'(o_rx_int), 32'd0);
        bus_issue(1'b1, 2'd1, 32'h0000_0002, 1'b0, 32'h0);
        bus_issue(1'b1, 2'd2, 32'h0001_0001, 1'b0, 32'h0);
        bus_idle();

        // 6: RX flush racing a stream push.
        for (int i = 0; i < 5; i++) rx_push(32'h61 + 32'(i));
        i_rx_stb  = 1'b1;
        i_rx_data = 32'h66;
        bus_issue(1'b1, 2'd1, 32'h0000_0002, 1'b0, 32'h0);
        i_rx_stb = 1'b0;
        check("rx_busy_after_flush", 32'(o_rx_busy), 32'd0);
        bus_issue(1'b0, 2'd1, 32'h0, 1'b0, 32'h0000_0000);
        bus_issue(1'b0, 2'd0, 32'h0, 1'b1, 32'h0);
        bus_issue(1'b0, 2'd1, 32'h0, 1'b0, 32'h4000_0000);
        bus_issue(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0);
        bus_issue(1'b0, 2'd3, 32'h0, 1'b0, 32'h0);
        bus_issue(1'b0, 2'd2, 32'h0, 1'b0, 32'h0001_0001);
        bus_idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge i_clk);
        #1;
        check("wb_pending_responses", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
